// File: rtl/ecc_pkg.sv
// Shared ECC definitions: SEC1 point-encoding prefixes, decoder result codes and
// decoder state encoding.
package ecc_pkg;

    localparam logic [7:0] SEC1_PFX_UNCOMP    = 8'h04;
    localparam logic [7:0] SEC1_PFX_COMP_EVEN = 8'h02;
    localparam logic [7:0] SEC1_PFX_COMP_ODD  = 8'h03;

    typedef enum logic [1:0] {
        SEC1_OK         = 2'd0,
        SEC1_BAD_PREFIX = 2'd1,
        SEC1_SHORT      = 2'd2,
        SEC1_LONG       = 2'd3
    } sec1_err_e;

    typedef enum logic [2:0] {
        PREFIX,
        X,
        Y,
        DRAIN,
        OUT
    } sec1_dec_state_e;

endpackage

// File: rtl/sec1_point_decoder_coord_shift.sv
// Byte-wide shift register holding one big-endian EC coordinate; new bytes enter
// at the LSB end so the first byte received ends up in the MSB position.
module sec1_coord_shift #(
    parameter int COORD_BYTES = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     en,
    input  logic [7:0]               din,
    output logic [8*COORD_BYTES-1:0] q
);

    // NOTE: the coordinate register has defined reset contents, so it is reset
    // like ordinary control state rather than left as an unreset datapath.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (en) begin
            q <= {q[8*COORD_BYTES-9:0], din};
        end
    end

endmodule

// File: rtl/sec1_point_decoder.sv
// SEC1 octet-string point decoder: prefix || X || Y -> parallel coordinate words.
// Optional compressed-point support (0x02/0x03, X only) under SEC1_COMPRESSED_POINT_EN.
module sec1_point_decoder
    import ecc_pkg::*;
#(
    parameter int COORD_BYTES = 32,
    parameter int CNT_W       = $clog2(COORD_BYTES)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               s_data,
    input  logic                     s_valid,
    input  logic                     s_last,
    output logic                     s_ready,
    output logic [8*COORD_BYTES-1:0] m_x,
    output logic [8*COORD_BYTES-1:0] m_y,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     m_err,
    output logic [1:0]               m_err_code,
    output logic                     m_y_parity
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(COORD_BYTES - 1);

    sec1_dec_state_e  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    sec1_err_e        code_q, code_d;
    logic             par_q, par_d;
    logic             comp_q, comp_d;
    logic             clr, x_en, y_en;
    logic             fire;

    assign s_ready = (state_q != OUT);
    assign fire    = s_valid && s_ready;

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        par_d   = par_q;
        comp_d  = comp_q;
        clr     = 1'b0;
        x_en    = 1'b0;
        y_en    = 1'b0;

        case (state_q)
            PREFIX: begin
                if (fire) begin
                    clr    = 1'b1;
                    cnt_d  = '0;
                    par_d  = 1'b0;
                    comp_d = 1'b0;
                    code_d = SEC1_OK;
                    if (s_data == SEC1_PFX_UNCOMP) begin
                        if (s_last) begin
                            state_d = OUT;
                            code_d  = SEC1_SHORT;
                        end else begin
                            state_d = X;
                        end
                    end
`ifdef SEC1_COMPRESSED_POINT_EN
                    else if (s_data == SEC1_PFX_COMP_EVEN || s_data == SEC1_PFX_COMP_ODD) begin
                        comp_d = 1'b1;
                        par_d  = s_data[0];
                        if (s_last) begin
                            state_d = OUT;
                            code_d  = SEC1_SHORT;
                        end else begin
                            state_d = X;
                        end
                    end
`endif
                    else begin
                        code_d  = SEC1_BAD_PREFIX;
                        state_d = s_last ? OUT : DRAIN;
                    end
                end
            end

            X: begin
                if (fire) begin
                    x_en = 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        cnt_d = '0;
                        if (comp_q) begin
                            // Compressed points end after X; anything further is LONG.
                            if (s_last) begin
                                state_d = OUT;
                                code_d  = SEC1_OK;
                            end else begin
                                state_d = DRAIN;
                                code_d  = SEC1_LONG;
                            end
                        end else if (s_last) begin
                            state_d = OUT;
                            code_d  = SEC1_SHORT;
                        end else begin
                            state_d = Y;
                        end
                    end else if (s_last) begin
                        state_d = OUT;
                        code_d  = SEC1_SHORT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            Y: begin
                if (fire) begin
                    y_en = 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        cnt_d = '0;
                        if (s_last) begin
                            state_d = OUT;
                            code_d  = SEC1_OK;
                        end else begin
                            state_d = DRAIN;
                            code_d  = SEC1_LONG;
                        end
                    end else if (s_last) begin
                        state_d = OUT;
                        code_d  = SEC1_SHORT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            DRAIN: begin
                if (fire && s_last) begin
                    state_d = OUT;
                end
            end

            OUT: begin
                if (m_ready) begin
                    state_d = PREFIX;
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d = PREFIX;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PREFIX;
            cnt_q   <= '0;
            code_q  <= SEC1_OK;
            par_q   <= 1'b0;
            comp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            par_q   <= par_d;
            comp_q  <= comp_d;
        end
    end

    sec1_coord_shift #(.COORD_BYTES(COORD_BYTES)) u_x_shift (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .en  (x_en),
        .din (s_data),
        .q   (m_x)
    );

    // Cleared on every prefix, so a compressed point leaves m_y at zero.
    sec1_coord_shift #(.COORD_BYTES(COORD_BYTES)) u_y_shift (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .en  (y_en),
        .din (s_data),
        .q   (m_y)
    );

    assign m_valid    = (state_q == OUT);
    assign m_err      = (code_q != SEC1_OK);
    assign m_err_code = code_q;
    assign m_y_parity = par_q;

endmodule

// File: tb/tb_sec1_point_decoder.sv
// Self-checking bench for sec1_point_decoder: directed SEC1 encodings plus random
// traffic compared every cycle against a whole-message length/prefix model.
module tb_sec1_point_decoder;

    localparam int C    = 32;
    localparam int W    = 8 * C;
    localparam int NEED = 1 + 2 * C;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   s_data;
    logic         s_valid, s_last, s_ready;
    logic [W-1:0] m_x, m_y;
    logic         m_valid, m_ready, m_err, m_y_parity;
    logic [1:0]   m_err_code;

    sec1_point_decoder #(.COORD_BYTES(C)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .m_x        (m_x),
        .m_y        (m_y),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_err      (m_err),
        .m_err_code (m_err_code),
        .m_y_parity (m_y_parity)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: buffer the whole encoding, judge it by prefix and length.
    logic [7:0]   msg[$];
    bit           pend = 1'b0;
    logic [1:0]   e_code;
    logic [W-1:0] e_x, e_y;
    bit           e_par;

    function automatic void evaluate();
        int         n    = msg.size();
        int         need = NEED;
        bit         comp = 1'b0;
        logic [7:0] p    = msg[0];
        e_x   = '0;
        e_y   = '0;
        e_par = 1'b0;
        if (p == 8'h04) begin
            need = NEED;
        end
`ifdef SEC1_COMPRESSED_POINT_EN
        else if (p == 8'h02 || p == 8'h03) begin
            need  = 1 + C;
            comp  = 1'b1;
            e_par = p[0];
        end
`endif
        else begin
            e_code = 2'd1;
            return;
        end
        if (n < need)      e_code = 2'd2;
        else if (n > need) e_code = 2'd3;
        else begin
            e_code = 2'd0;
            for (int i = 0; i < C; i++) begin
                e_x[W-1-8*i -: 8] = msg[1+i];
                if (!comp) e_y[W-1-8*i -: 8] = msg[1+C+i];
            end
        end
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            msg.delete();
            pend = 1'b0;
        end else if (pend) begin
            if (m_ready) pend = 1'b0;
        end else if (s_valid) begin
            msg.push_back(s_data);
            if (s_last) begin
                evaluate();
                msg.delete();
                pend = 1'b1;
            end
        end
    end

    // Consumer side: always ready, held off, or random.
    bit mr_hold = 1'b0;
    bit mr_rand = 1'b0;
    always @(posedge clk) begin
        #1;
        m_ready = mr_hold ? 1'b0 : (mr_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    end

    // Per-cycle compare, including output stability while a result is stalled.
    bit           chk_en = 1'b0;
    bit           prev_hold = 1'b0;
    logic [W-1:0] prev_x, prev_y;
    logic [1:0]   prev_code;
    always @(negedge clk) begin
        if (chk_en) begin
            check("s_ready", s_ready, !pend);
            check("m_valid", m_valid, pend);
            if (pend) begin
                check("m_err", m_err, e_code != 2'd0);
                check("m_err_code", m_err_code, e_code);
                if (e_code == 2'd0) begin
                    check("m_x", m_x, e_x);
                    check("m_y", m_y, e_y);
                    check("m_y_parity", m_y_parity, e_par);
                end
                if (prev_hold) begin
                    check("hold_m_x", m_x, prev_x);
                    check("hold_m_y", m_y, prev_y);
                    check("hold_code", m_err_code, prev_code);
                end
            end
            prev_hold = pend && !m_ready && !rst;
            prev_x    = m_x;
            prev_y    = m_y;
            prev_code = m_err_code;
        end
    end

    task automatic send(input logic [7:0] b[$], input bit gaps, input bit last_on_end);
        foreach (b[i]) begin
            int t = 0;
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                @(posedge clk); #1;
            end
            while (pend && t < 300) begin
                s_valid = 1'b0;
                @(posedge clk); #1;
                t++;
            end
            if (pend) begin
                vectors++;
                miscompares++;
                $display("FAIL send_timeout: result never consumed");
                s_valid = 1'b0;
                s_last  = 1'b0;
                return;
            end
            s_data  = b[i];
            s_last  = last_on_end && (i == b.size() - 1);
            s_valid = 1'b1;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (pend && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        vectors++;
        if (pend) begin
            miscompares++;
            $display("FAIL idle_timeout: result still pending");
        end
    endtask

    function automatic void build(output logic [7:0] b[$], input logic [7:0] pfx,
                                  input int nbytes, input int first);
        b.delete();
        b.push_back(pfx);
        for (int i = 0; i < nbytes; i++) b.push_back(8'(first + i));
    endfunction

    initial begin
        logic [7:0]   b[$];
        logic [W-1:0] lit_x, lit_y;
        lit_x = 256'h0102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f20;
        lit_y = 256'h2122232425262728292a2b2c2d2e2f303132333435363738393a3b3c3d3e3f40;

        rst     = 1'b1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 8'h00;
        m_ready = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        @(negedge clk);
        check("rst_s_ready", s_ready, 1'b1);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_x", m_x, '0);
        check("rst_m_y", m_y, '0);
        check("rst_m_err", m_err, 1'b0);
        check("rst_code", m_err_code, 2'd0);
        check("rst_parity", m_y_parity, 1'b0);
        @(posedge clk); #1;

        // Known good point, result expected the cycle after the last byte.
        build(b, 8'h04, 2 * C, 1);
        send(b, 1'b0, 1'b1);
        @(negedge clk);
        check("ok_valid", m_valid, 1'b1);
        check("ok_x_literal", m_x, lit_x);
        check("ok_y_literal", m_y, lit_y);
        check("ok_err", m_err, 1'b0);
        @(posedge clk); #1;

        build(b, 8'h05, 64, 0);
        send(b, 1'b0, 1'b1);
        @(negedge clk);
        check("badpfx_code", m_err_code, 2'd1);
        check("badpfx_err", m_err, 1'b1);
        @(posedge clk); #1;

        build(b, 8'h04, 40, 0);
        send(b, 1'b0, 1'b1);
        @(negedge clk);
        check("short_valid", m_valid, 1'b1);
        check("short_code", m_err_code, 2'd2);
        @(posedge clk); #1;

        build(b, 8'h04, 66, 0);
        send(b, 1'b0, 1'b1);
        @(negedge clk);
        check("long_code", m_err_code, 2'd3);
        @(posedge clk); #1;

        // Stalled consumer, then back-to-back encodings.
        mr_hold = 1'b1;
        build(b, 8'h04, 2 * C, 8'h90);
        send(b, 1'b0, 1'b1);
        repeat (10) begin
            @(negedge clk);
            check("hold_s_ready", s_ready, 1'b0);
        end
        @(posedge clk); #1;
        mr_hold = 1'b0;
        build(b, 8'h04, 2 * C, 8'h10);
        send(b, 1'b0, 1'b1);
        build(b, 8'h04, 2 * C, 8'h50);
        send(b, 1'b0, 1'b1);
        wait_idle();

        // Reset in the middle of Y aborts silently.
        build(b, 8'h04, C + 10, 8'h33);
        send(b, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_m_valid", m_valid, 1'b0);
        check("abort_m_x", m_x, '0);
        @(posedge clk); #1;
        build(b, 8'h04, 2 * C, 1);
        send(b, 1'b0, 1'b1);
        @(negedge clk);
        check("after_abort_code", m_err_code, 2'd0);
        check("after_abort_x", m_x, lit_x);
        @(posedge clk); #1;

        // Compressed point with odd Y.
        build(b, 8'h03, C, 1);
        send(b, 1'b0, 1'b1);
        @(negedge clk);
`ifdef SEC1_COMPRESSED_POINT_EN
        check("comp_err", m_err, 1'b0);
        check("comp_parity", m_y_parity, 1'b1);
        check("comp_m_y", m_y, '0);
`else
        check("comp_code", m_err_code, 2'd1);
`endif
        @(posedge clk); #1;

        // Random traffic with input gaps and a random consumer.
        mr_rand = 1'b1;
        for (int k = 0; k < 60; k++) begin
            logic [7:0] pfx;
            int         n;
            int         r = int'($urandom_range(0, 9));
            if (r <= 5)      pfx = 8'h04;
            else if (r == 6) pfx = 8'h02;
            else if (r == 7) pfx = 8'h03;
            else if (r == 8) pfx = 8'($urandom);
            else             pfx = 8'h05;
            r = int'($urandom_range(0, 3));
            if (r == 0)      n = C;
            else if (r == 1) n = 2 * C;
            else             n = int'($urandom_range(0, 2 * C + 6));
            b.delete();
            b.push_back(pfx);
            for (int i = 0; i < n; i++) b.push_back(8'($urandom));
            send(b, 1'b1, 1'b1);
        end
        mr_rand = 1'b0;
        wait_idle();
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
